// File: rtl/solar_tracker_optimizer_pkg.sv
// Shared types and default timing for the two-axis solar tracker.
// State encoding is visible on STAT, so the values are fixed.
package sp_tracker_pkg;

    typedef enum logic [2:0] {
        ST_MANUAL  = 3'd0,
        ST_SWEEP_H = 3'd1,
        ST_GOTO_H  = 3'd2,
        ST_SWEEP_V = 3'd3,
        ST_GOTO_V  = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_NEG  = 2'b01,
        DIR_POS  = 2'b10
    } dir_t;

    localparam int unsigned DEF_PWM_PERIOD = 2_000_000;
    localparam int unsigned DEF_POS_MIN    = 100_000;
    localparam int unsigned DEF_POS_MAX    = 200_000;
    localparam int unsigned DEF_POS_MID    = 150_000;
    localparam int unsigned DEF_STEP       = 1_000;
    localparam int unsigned DEF_TICK_DIV   = 100_000;

    // One step toward a bound; clamps instead of wrapping.
    function automatic logic [31:0] step_sat(input logic [31:0] pos, input logic up,
                                             input logic [31:0] step,
                                             input logic [31:0] pmin, input logic [31:0] pmax);
        if (up) return (pos + step >= pmax) ? pmax : pos + step;
        else    return (pos <= pmin + step) ? pmin : pos - step;
    endfunction

endpackage

// File: rtl/solar_tracker_optimizer_if.sv
// Button/ADC inputs and servo/status outputs of the tracker.
// The tracker uses the slave view; its environment uses the master view.
interface solar_tracker_optimizer_if;
    logic        BTN_L, BTN_R, BTN_U, BTN_D, BTN_C;
    logic        DBG;
    logic [11:0] V_in;
    logic        SERVO_H, SERVO_V;
    logic [31:0] servo_position_H, servo_position_V;
    logic [11:0] max_V_in;
    logic [31:0] pulseWidth_max_H, pulseWidth_max_V;
    logic [2:0]  STAT;
    logic [1:0]  direction_lr, direction_ud;
    logic        servo_l, servo_r, servo_u, servo_d;
    logic        PWM_limit_H, PWM_limit_V;
    logic        HS, VS, MC;
    logic        div_clk;

    modport master (
        output BTN_L, BTN_R, BTN_U, BTN_D, BTN_C, DBG, V_in,
        input  SERVO_H, SERVO_V, servo_position_H, servo_position_V, max_V_in,
               pulseWidth_max_H, pulseWidth_max_V, STAT, direction_lr, direction_ud,
               servo_l, servo_r, servo_u, servo_d, PWM_limit_H, PWM_limit_V,
               HS, VS, MC, div_clk
    );

    modport slave (
        input  BTN_L, BTN_R, BTN_U, BTN_D, BTN_C, DBG, V_in,
        output SERVO_H, SERVO_V, servo_position_H, servo_position_V, max_V_in,
               pulseWidth_max_H, pulseWidth_max_V, STAT, direction_lr, direction_ud,
               servo_l, servo_r, servo_u, servo_d, PWM_limit_H, PWM_limit_V,
               HS, VS, MC, div_clk
    );
endinterface

// File: rtl/solar_tracker_optimizer_servo_pwm.sv
// Free-running servo frame counter with a pulse width latched at frame start,
// so a position change never produces a runt or stretched pulse mid-frame.
module servo_pwm #(
    parameter int unsigned PERIOD = 2_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pos,
    output logic        o_pwm
);
    localparam logic [31:0] CNT_LAST = 32'(PERIOD - 1);

    logic [31:0] r_cnt;
    logic [31:0] r_duty;
    logic        r_pwm;
    logic [31:0] w_duty;

    assign w_duty = (r_cnt == '0) ? i_pos : r_duty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 32'd1;
            r_duty <= w_duty;
            r_pwm  <= (r_cnt < w_duty);
        end
    end

    assign o_pwm = r_pwm;
endmodule

// File: rtl/solar_tracker_optimizer.sv
// Two-axis tracker: manual jog of H/V servos, or an automatic sweep of each
// axis that parks it at the position of highest panel voltage.
module solar_tracker_optimizer
    import sp_tracker_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int unsigned POS_MIN    = DEF_POS_MIN,
    parameter int unsigned POS_MAX    = DEF_POS_MAX,
    parameter int unsigned POS_MID    = DEF_POS_MID,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic RST,
    solar_tracker_optimizer_if.slave bus
);
    localparam logic [31:0] P_MIN     = 32'(POS_MIN);
    localparam logic [31:0] P_MAX     = 32'(POS_MAX);
    localparam logic [31:0] P_MID     = 32'(POS_MID);
    localparam logic [31:0] P_STEP    = 32'(STEP);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic [4:0]  r_btn_meta, r_btn_sync;
    logic        w_l, w_r, w_u, w_d, w_c;
    logic [31:0] r_tick_cnt;
    logic        r_div, w_tick;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_pos_h, r_pos_v, r_pwmax_h, r_pwmax_v;
    logic [31:0] w_pos_h_nxt, w_pos_v_nxt, w_pwmax_h_nxt, w_pwmax_v_nxt;
    logic [11:0] r_max_v, w_max_v_nxt;
    logic        r_hs, r_vs, w_hs_nxt, w_vs_nxt;
    dir_t        r_dir_lr, r_dir_ud, w_dir_lr_nxt, w_dir_ud_nxt;
    logic        w_servo_h, w_servo_v;

    assign {w_c, w_d, w_u, w_r, w_l} = r_btn_sync;
    assign w_tick = !bus.DBG && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_tick_cnt <= '0;
            r_div      <= 1'b0;
        end else begin
            r_btn_meta <= {bus.BTN_C, bus.BTN_D, bus.BTN_U, bus.BTN_R, bus.BTN_L};
            r_btn_sync <= r_btn_meta;
            if (!bus.DBG) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
            if (w_tick)   r_div      <= ~r_div;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pos_h_nxt   = r_pos_h;
        w_pos_v_nxt   = r_pos_v;
        w_pwmax_h_nxt = r_pwmax_h;
        w_pwmax_v_nxt = r_pwmax_v;
        w_max_v_nxt   = r_max_v;
        w_hs_nxt      = r_hs;
        w_vs_nxt      = r_vs;
        w_dir_lr_nxt  = r_dir_lr;
        w_dir_ud_nxt  = r_dir_ud;
        if (!bus.DBG) begin
            case (r_state)
                ST_MANUAL: begin
                    w_dir_lr_nxt = (w_l && !w_r) ? DIR_NEG : (w_r && !w_l) ? DIR_POS : DIR_IDLE;
                    w_dir_ud_nxt = (w_u && !w_d) ? DIR_NEG : (w_d && !w_u) ? DIR_POS : DIR_IDLE;
                    if (w_c) begin
                        w_state_nxt  = ST_SWEEP_H;
                        w_pos_h_nxt  = P_MIN;
                        w_max_v_nxt  = '0;
                        w_hs_nxt     = 1'b0;
                        w_vs_nxt     = 1'b0;
                        w_dir_lr_nxt = DIR_IDLE;
                        w_dir_ud_nxt = DIR_IDLE;
                    end else if (w_tick) begin
                        if (w_dir_lr_nxt != DIR_IDLE)
                            w_pos_h_nxt = step_sat(r_pos_h, w_dir_lr_nxt == DIR_POS, P_STEP, P_MIN, P_MAX);
                        if (w_dir_ud_nxt != DIR_IDLE)
                            w_pos_v_nxt = step_sat(r_pos_v, w_dir_ud_nxt == DIR_POS, P_STEP, P_MIN, P_MAX);
                    end
                end
                ST_SWEEP_H: begin
                    // Strict compare: equal later readings keep the earlier position.
                    if (bus.V_in > r_max_v) begin
                        w_max_v_nxt   = bus.V_in;
                        w_pwmax_h_nxt = r_pos_h;
                    end
                    if (r_pos_h == P_MAX) w_state_nxt = ST_GOTO_H;
                    else if (w_tick)      w_pos_h_nxt = step_sat(r_pos_h, 1'b1, P_STEP, P_MIN, P_MAX);
                end
                ST_GOTO_H: begin
                    w_pos_h_nxt = r_pwmax_h;
                    w_hs_nxt    = 1'b1;
                    w_max_v_nxt = '0;
                    w_pos_v_nxt = P_MIN;
                    w_state_nxt = ST_SWEEP_V;
                end
                ST_SWEEP_V: begin
                    if (bus.V_in > r_max_v) begin
                        w_max_v_nxt   = bus.V_in;
                        w_pwmax_v_nxt = r_pos_v;
                    end
                    if (r_pos_v == P_MAX) w_state_nxt = ST_GOTO_V;
                    else if (w_tick)      w_pos_v_nxt = step_sat(r_pos_v, 1'b1, P_STEP, P_MIN, P_MAX);
                end
                ST_GOTO_V: begin
                    w_pos_v_nxt = r_pwmax_v;
                    w_vs_nxt    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_c) begin
                        w_state_nxt = ST_SWEEP_H;
                        w_pos_h_nxt = P_MIN;
                        w_max_v_nxt = '0;
                        w_hs_nxt    = 1'b0;
                        w_vs_nxt    = 1'b0;
                    end else if (w_l || w_r || w_u || w_d) begin
                        w_state_nxt = ST_MANUAL;
                    end
                end
                default: w_state_nxt = ST_MANUAL;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_MANUAL;
            r_pos_h   <= P_MID;
            r_pos_v   <= P_MID;
            r_pwmax_h <= P_MID;
            r_pwmax_v <= P_MID;
            r_max_v   <= '0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_dir_lr  <= DIR_IDLE;
            r_dir_ud  <= DIR_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_pos_h   <= w_pos_h_nxt;
            r_pos_v   <= w_pos_v_nxt;
            r_pwmax_h <= w_pwmax_h_nxt;
            r_pwmax_v <= w_pwmax_v_nxt;
            r_max_v   <= w_max_v_nxt;
            r_hs      <= w_hs_nxt;
            r_vs      <= w_vs_nxt;
            r_dir_lr  <= w_dir_lr_nxt;
            r_dir_ud  <= w_dir_ud_nxt;
        end
    end

    servo_pwm #(.PERIOD(PWM_PERIOD)) u_pwm_h (
        .i_clk(CLK), .i_rst(RST), .i_pos(r_pos_h), .o_pwm(w_servo_h)
    );
    servo_pwm #(.PERIOD(PWM_PERIOD)) u_pwm_v (
        .i_clk(CLK), .i_rst(RST), .i_pos(r_pos_v), .o_pwm(w_servo_v)
    );

    assign bus.SERVO_H          = w_servo_h;
    assign bus.SERVO_V          = w_servo_v;
    assign bus.servo_position_H = r_pos_h;
    assign bus.servo_position_V = r_pos_v;
    assign bus.max_V_in         = r_max_v;
    assign bus.pulseWidth_max_H = r_pwmax_h;
    assign bus.pulseWidth_max_V = r_pwmax_v;
    assign bus.STAT             = r_state;
    assign bus.direction_lr     = r_dir_lr;
    assign bus.direction_ud     = r_dir_ud;
    assign bus.servo_l          = w_l;
    assign bus.servo_r          = w_r;
    assign bus.servo_u          = w_u;
    assign bus.servo_d          = w_d;
    assign bus.PWM_limit_H      = (r_pos_h == P_MIN) || (r_pos_h == P_MAX);
    assign bus.PWM_limit_V      = (r_pos_v == P_MIN) || (r_pos_v == P_MAX);
    assign bus.HS               = r_hs;
    assign bus.VS               = r_vs;
    assign bus.MC               = (r_state == ST_MANUAL);
    assign bus.div_clk          = r_div;
endmodule

// File: tb/tb_solar_tracker_optimizer.sv
// Bench for solar_tracker_optimizer: directed jogs and sweeps plus random
// jogs and random voltage landscapes, checked against a position model.
module tb_solar_tracker_optimizer;
    localparam int PER = 1000, PMIN = 100, PMAX = 200, PMID = 150, STP = 10, TDIV = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    solar_tracker_optimizer_if bus();

    solar_tracker_optimizer #(
        .PWM_PERIOD(PER), .POS_MIN(PMIN), .POS_MAX(PMAX),
        .POS_MID(PMID), .STEP(STP), .TICK_DIV(TDIV)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );

    int n_checks = 0, n_errors = 0;
    int m_h, m_v;
    int g_th = 0, g_ah = 0, g_tv = 0, g_av = 0, g_base = 0;

    // Panel voltage landscape: a peak at one H position plus a peak at one V position.
    always @(negedge clk) begin
        int v;
        v = g_base;
        if (bus.servo_position_H == 32'(g_th)) v += g_ah;
        if (bus.servo_position_V == 32'(g_tv)) v += g_av;
        bus.V_in = 12'(v);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        logic d0;
        bit   seen;
        d0   = bus.div_clk;
        seen = 0;
        for (int i = 0; i < 4 * TDIV && !seen; i++) begin
            @(negedge clk);
            if (bus.div_clk !== d0) seen = 1;
        end
        if (!seen) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_high(input bit vert, output int cnt);
        cnt = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (vert ? bus.SERVO_V : bus.SERVO_H) cnt++;
        end
    endtask

    function automatic int clamp(input int p);
        if (p < PMIN) return PMIN;
        if (p > PMAX) return PMAX;
        return p;
    endfunction

    task automatic jog(input bit l, input bit r, input bit u, input bit d, input int n);
        wait_tick();
        bus.BTN_L = l; bus.BTN_R = r; bus.BTN_U = u; bus.BTN_D = d;
        for (int k = 0; k < n; k++) begin
            wait_tick();
            if (l && !r) m_h = clamp(m_h - STP);
            if (r && !l) m_h = clamp(m_h + STP);
            if (u && !d) m_v = clamp(m_v - STP);
            if (d && !u) m_v = clamp(m_v + STP);
        end
        chk("pos_h", bus.servo_position_H, 32'(m_h));
        chk("pos_v", bus.servo_position_V, 32'(m_v));
        chk("dir_lr", 32'(bus.direction_lr), (l && !r) ? 1 : (r && !l) ? 2 : 0);
        chk("dir_ud", 32'(bus.direction_ud), (u && !d) ? 1 : (d && !u) ? 2 : 0);
        chk("lim_h", 32'(bus.PWM_limit_H), (m_h == PMIN || m_h == PMAX) ? 1 : 0);
        chk("lim_v", 32'(bus.PWM_limit_V), (m_v == PMIN || m_v == PMAX) ? 1 : 0);
        chk("sync_lrud", {28'd0, bus.servo_l, bus.servo_r, bus.servo_u, bus.servo_d},
            {28'd0, l, r, u, d});
        chk("mc", 32'(bus.MC), 32'd1);
        bus.BTN_L = 0; bus.BTN_R = 0; bus.BTN_U = 0; bus.BTN_D = 0;
    endtask

    task automatic sweep(input int th, input int ah, input int tv, input int av, input int base);
        int  code, last, eh, ev, emax, hs3, vs3;
        bit  done;
        g_th = th; g_ah = ah; g_tv = tv; g_av = av; g_base = base;
        @(negedge clk);
        last = int'(bus.STAT); code = 0; done = 0; hs3 = -1; vs3 = -1;
        bus.BTN_C = 1;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge clk);
            if (i == 3) bus.BTN_C = 0;
            if (int'(bus.STAT) != last) begin
                last = int'(bus.STAT);
                code = code * 8 + last;
                if (last == 3) begin hs3 = int'(bus.HS); vs3 = int'(bus.VS); end
            end
            if (last == 5 && code != 0) done = 1;
        end
        if (!done) chk("sweep_timeout", 32'd0, 32'd1);
        eh   = (ah > 0) ? th : PMIN;
        ev   = (av > 0) ? tv : PMIN;
        emax = base + ((eh == th) ? ah : 0) + ((ev == tv) ? av : 0);
        chk("stat_seq", 32'(code), 32'o12345);
        chk("hs_at_sweep_v", 32'(hs3), 32'd1);
        chk("vs_at_sweep_v", 32'(vs3), 32'd0);
        chk("hold_hs", 32'(bus.HS), 32'd1);
        chk("hold_vs", 32'(bus.VS), 32'd1);
        chk("park_h", bus.servo_position_H, 32'(eh));
        chk("park_v", bus.servo_position_V, 32'(ev));
        chk("pwmax_h", bus.pulseWidth_max_H, 32'(eh));
        chk("pwmax_v", bus.pulseWidth_max_V, 32'(ev));
        chk("max_v_in", 32'(bus.max_V_in), 32'(emax));
        chk("hold_mc", 32'(bus.MC), 32'd0);
        m_h = eh; m_v = ev;
    endtask

    task automatic leave_hold();
        wait_tick();
        bus.BTN_R = 1;
        repeat (4) @(negedge clk);
        chk("leave_stat", 32'(bus.STAT), 32'd0);
        chk("leave_mc", 32'(bus.MC), 32'd1);
        bus.BTN_R = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, d0, gap;
        bit frozen;
        rst = 1;
        bus.BTN_L = 0; bus.BTN_R = 0; bus.BTN_U = 0; bus.BTN_D = 0; bus.BTN_C = 0;
        bus.DBG = 0;
        m_h = PMID; m_v = PMID;
        repeat (10) @(negedge clk);
        rst = 0;

        chk("rst_h", bus.servo_position_H, 32'(PMID));
        chk("rst_v", bus.servo_position_V, 32'(PMID));
        chk("rst_stat", 32'(bus.STAT), 32'd0);
        chk("rst_mc", 32'(bus.MC), 32'd1);
        chk("rst_max", 32'(bus.max_V_in), 32'd0);
        chk("rst_servo", {30'd0, bus.SERVO_H, bus.SERVO_V}, 32'd0);
        count_high(0, cnt);
        chk("pwm_h_mid", 32'(cnt), 32'(PMID));
        count_high(1, cnt);
        chk("pwm_v_mid", 32'(cnt), 32'(PMID));

        wait_tick();
        gap = 0; d0 = int'(bus.div_clk);
        while (int'(bus.div_clk) == d0 && gap < 50) begin @(negedge clk); gap++; end
        chk("tick_period", 32'(gap), 32'(TDIV));

        jog(1, 0, 0, 0, 5);
        chk("jog_l_h", bus.servo_position_H, 32'(PMIN));
        jog(1, 0, 0, 0, 2);
        jog(1, 1, 0, 0, 2);
        jog(0, 0, 0, 1, 3);
        chk("jog_d_v", bus.servo_position_V, 32'd180);
        jog(0, 0, 1, 1, 2);
        repeat (PER) @(negedge clk);
        count_high(0, cnt);
        chk("pwm_h_min", 32'(cnt), 32'(PMIN));

        for (int i = 0; i < 25; i++)
            jog(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(1, 3));

        // Freeze: positions and tick hold, PWM keeps running.
        wait_tick();
        bus.DBG = 1; bus.BTN_R = 1; bus.BTN_D = 1;
        d0 = int'(bus.div_clk); frozen = 1;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (int'(bus.div_clk) != d0) frozen = 0;
        end
        chk("dbg_tick", 32'(frozen), 32'd1);
        chk("dbg_h", bus.servo_position_H, 32'(m_h));
        chk("dbg_v", bus.servo_position_V, 32'(m_v));
        count_high(0, cnt);
        chk("dbg_pwm_h", 32'(cnt), 32'(m_h));
        bus.BTN_R = 0; bus.BTN_D = 0;
        repeat (3) @(negedge clk);
        bus.DBG = 0;

        sweep(160, 2900, 130, 1000, 100);
        leave_hold();
        sweep(150, 0, 120, 700, 50);
        for (int i = 0; i < 3; i++)
            sweep(PMIN + STP * $urandom_range(0, 10), $urandom_range(1, 1500),
                  PMIN + STP * $urandom_range(0, 10), $urandom_range(1, 1500),
                  $urandom_range(1, 500));
        leave_hold();
        for (int i = 0; i < 8; i++)
            jog(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(1, 3));

        // Reset in the middle of the vertical sweep.
        bus.BTN_C = 1;
        repeat (4) @(negedge clk);
        bus.BTN_C = 0;
        gap = 0;
        while (bus.STAT != 3'd3 && gap < 400) begin @(negedge clk); gap++; end
        chk("reach_sweep_v", 32'(bus.STAT), 32'd3);
        repeat (5) @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_h", bus.servo_position_H, 32'(PMID));
        chk("mid_rst_v", bus.servo_position_V, 32'(PMID));
        chk("mid_rst_stat", 32'(bus.STAT), 32'd0);
        chk("mid_rst_mc", 32'(bus.MC), 32'd1);
        chk("mid_rst_max", 32'(bus.max_V_in), 32'd0);
        chk("mid_rst_pwmax", bus.pulseWidth_max_H, 32'(PMID));
        chk("mid_rst_flags", {27'd0, bus.HS, bus.VS, bus.SERVO_H, bus.SERVO_V, bus.div_clk}, 32'd0);
        chk("mid_rst_dirs", {28'd0, bus.direction_lr, bus.direction_ud}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
